mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the 8-word data memory.
- Accepts byte/half/word load and store requests from the core over a valid/ready handshake and drives the memory's word address, write data and write strobe.
- Consumes the memory's combinational read word.
- Performs alignment checks, sign/zero extension on loads, and read-modify-write for sub-word stores, because the memory is word-only.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load result; ignored on stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or reserved size.
- mem_addr  out  ADDR_W  word address to memory (latched req_addr; the memory ignores [1:0]).
- mem_wdata  out  DATA_W  word to write.
- mem_write  out  1  write strobe; the memory writes on the rising clock edge while it is high.
- mem_rdata  in  DATA_W  combinational read word from memory at mem_addr.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; all request latches and resp_rdata clear to 0.
  - resp_valid=0, resp_err=0, mem_write=0, mem_addr=0, mem_wdata=0, req_ready=1.
  - Asserting reset mid-operation drops mem_write immediately; the pending response is discarded.
- Outputs are decoded from registered state only. No combinational path runs from req_* to mem_* or resp_*.
- Byte lanes are little-endian:
  - Byte lane k = bits [8k+7:8k], k = addr[1:0].
  - Half lane = [15:0] if addr[1]=0, else [31:16].
- Error conditions:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - On any of these: resp_err=1, resp_rdata=0, and memory is never written.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write/size/signed/addr/wdata.
  - Go to RESP with err=1 if the request is erroneous; otherwise go to ACCESS.
- ACCESS (mem_addr = latched addr):
  - Load: resp_rdata <= extracted lane, sign- or zero-extended; go to RESP.
  - Word store: mem_write=1, mem_wdata=latched wdata; go to RESP.
  - Sub-word store: merge register <= mem_rdata with the target lane replaced by the low bits of wdata; mem_write=0; go to WRITE.
- WRITE: mem_write=1, mem_wdata=merge register; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE; resp_valid falls the next cycle.
  - There is no response bypass: a new request is accepted only in IDLE, the cycle after the response handshake.
- Latency from the acceptance edge to resp_valid high:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- mem_write is high for exactly one cycle per successful store and never for loads or errors.
- mem_addr and mem_wdata stay stable from ACCESS through WRITE.
- Address width: the full address is passed through with no range check; aliasing beyond the memory size is the memory's behaviour.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state encoding IDLE/ACCESS/WRITE/RESP.
  - the misalignment predicate as a function.
- One combinational sub-module, byte_lane_align, provides:
  - load extraction plus extension (word, addr[1:0], size, signed -> result).
  - store merge (old word, wdata, addr[1:0], size -> new word).

Test Plan:
- Reset with reset_n=0 mid-WRITE -> mem_write=0 within the same cycle, resp_valid=0, req_ready=1; preloaded word at 0x8 (0x11223344) remains unchanged.
- Word store 0xDEADBEEF at 0x8 -> mem_write high exactly one cycle (ACCESS), resp_valid 2 cycles after acceptance, resp_err=0; then word load at 0x8 -> resp_rdata=0xDEADBEEF.
- Memory 0x11223344 at 0x8, byte store 0xAB at 0x9 -> one ACCESS cycle with mem_write=0, then one WRITE cycle with mem_wdata=0x1122AB44; resp_valid 3 cycles after acceptance.
- Loads from the resulting 0x1122AB44:
  - Signed byte at 0x9 -> 0xFFFFFFAB.
  - Unsigned byte at 0x9 -> 0x000000AB.
  - Signed half at 0x8 -> 0xFFFFAB44.
  - Unsigned half at 0xA -> 0x00001122.
- Misaligned word store at 0x6, half load at 0x3, and size=11 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after acceptance, and mem_write never asserted.
- Backpressure: hold resp_ready=0 for 3 cycles after a load -> resp_valid, resp_rdata and resp_err stable, and req_ready=0 throughout; a req_valid held during this window is accepted only in the IDLE cycle after the handshake.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - size codes, FSM states and alignment predicate for the load/store unit
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Reserved size code is folded in so one predicate covers every error case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core request/response and data-memory bus bundle
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_write
  );

endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// rtl/mem_access_unit_byte_lane_align.sv - little-endian lane extraction/extension and sub-word store merge
module byte_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = word_i[{addr_lo, 3'b000} +: 8];
    half_v     = addr_lo[1] ? word_i[31:16] : word_i[15:0];
    load_data  = word_i;
    store_word = word_i;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_v[15]}}, half_v};
        if (addr_lo[1]) store_word[31:16] = wdata;
        else            store_word[15:0]  = wdata;
      end
      default: begin
        load_data  = word_i;
        store_word = word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit driving a word-only data memory with sub-word read-modify-write
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clock,
  input  logic reset_n,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;
  logic              word_store;

  byte_lane_align u_align (
    .word_i     (bus.mem_rdata),
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign word_store = write_q && (size_q == SZ_WORD);

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          err_d    = is_misaligned(bus.req_size, bus.req_addr[1:0]);
          state_d  = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rdata_d = load_data;
          state_d = RESP;
        end else if (word_store) begin
          state_d = RESP;
        end else begin
          merge_d = store_word;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RESP;
      default: if (bus.resp_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merge_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
      err_q    <= err_d;
    end
  end

  // Sub-word ACCESS shows the merged word early so mem_wdata holds steady into WRITE.
  always_comb begin
    bus.mem_wdata = '0;
    if (state_q == ACCESS && write_q) bus.mem_wdata = word_store ? wdata_q : store_word;
    else if (state_q == WRITE)        bus.mem_wdata = merge_q;
  end

  assign bus.mem_write  = (state_q == ACCESS && word_store) || (state_q == WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with an 8-word memory model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clock;
  logic reset_n;
  logic mem_init;
  logic [31:0] mem [8];
  int n_checks;
  int n_fail;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= (i == 2) ? 32'h1122_3344 : 32'h0;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[4:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[4:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int nwr, output int first_wr, output logic [31:0] wd);
    lat = 0; nwr = 0; first_wr = 0; wd = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (bus.mem_write) begin
        nwr++;
        if (first_wr == 0) first_wr = n;
        wd = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_nwr, output int first_wr, output logic [31:0] wd);
    int lat, nwr;
    send(tag, w, sz, sg, a, d);
    wait_resp(lat, nwr, first_wr, wd);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, exp_err});
    check({tag, "_nwr"}, nwr, exp_nwr);
  endtask

  int fw, lat, nwr;
  logic [31:0] wd, held;

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; mem_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_mwr", {31'b0, bus.mem_write}, 32'd0);
    check("rst_maddr", bus.mem_addr, 32'h0);
    check("rst_mwdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    reset_n = 1'b1; mem_init = 1'b0;

    // Reset lands during the WRITE cycle of a byte store; the memory must be untouched.
    send("rstw", 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'hAB);
    @(negedge clock);
    check("rstw_access_mwr", {31'b0, bus.mem_write}, 32'd0);
    @(negedge clock);
    check("rstw_write_mwr", {31'b0, bus.mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstw_mwr_drop", {31'b0, bus.mem_write}, 32'd0);
    check("rstw_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rstw_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rstw_mem", mem[2], 32'h1122_3344);
    check("rstw_valid2", {31'b0, bus.resp_valid}, 32'd0);

    run_req("sw", 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, fw, wd);
    check("sw_first_wr", fw, 1);
    check("sw_wdata", wd, 32'hDEAD_BEEF);
    run_req("lw", 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0, fw, wd);
    run_req("sw2", 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h1122_3344, 2, 32'h0, 1'b0, 1, fw, wd);

    run_req("sb", 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, fw, wd);
    check("sb_first_wr", fw, 2);
    check("sb_wdata", wd, 32'h1122_AB44);
    @(negedge clock);
    check("sb_mem", mem[2], 32'h1122_AB44);

    run_req("lbs", 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 2, 32'hFFFF_FFAB, 1'b0, 0, fw, wd);
    run_req("lbu", 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 2, 32'h0000_00AB, 1'b0, 0, fw, wd);
    run_req("lhs", 1'b0, SZ_HALF, 1'b1, 32'h8, 32'h0, 2, 32'hFFFF_AB44, 1'b0, 0, fw, wd);
    run_req("lhu", 1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, 2, 32'h0000_1122, 1'b0, 0, fw, wd);

    run_req("err_sw6", 1'b1, SZ_WORD, 1'b0, 32'h6, 32'hCAFE_F00D, 1, 32'h0, 1'b1, 0, fw, wd);
    run_req("err_lh3", 1'b0, SZ_HALF, 1'b1, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0, fw, wd);
    run_req("err_sz3", 1'b1, 2'b11, 1'b0, 32'h0, 32'h1234_5678, 1, 32'h0, 1'b1, 0, fw, wd);
    @(negedge clock);
    check("err_mem1", mem[1], 32'h0);
    check("err_mem0", mem[0], 32'h0);

    // Response backpressure with a second request waiting on req_valid.
    bus.resp_ready = 1'b0;
    send("bp", 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0);
    wait_resp(lat, nwr, fw, wd);
    check("bp_lat", lat, 2);
    held = bus.resp_rdata;
    check("bp_rdata", held, 32'hFFFF_FFAB);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SZ_HALF;
    bus.req_signed = 1'b0; bus.req_addr = 32'hA; bus.req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_hold_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("bp_hold_rdata", bus.resp_rdata, 32'hFFFF_FFAB);
      check("bp_hold_err", {31'b0, bus.resp_err}, 32'd0);
      check("bp_hold_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("bp_idle_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("bp_idle_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    wait_resp(lat, nwr, fw, wd);
    check("bp2_lat", lat, 2);
    check("bp2_rdata", bus.resp_rdata, 32'h0000_1122);
    check("bp2_nwr", nwr, 0);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
